// File: rtl/jtag_pkg.sv
// jtag_pkg: shared command codes, FSM states and TMS sequence helpers for the JTAG master
package jtag_pkg;
  typedef enum logic [1:0] {CMD_RESET, CMD_SHIFT_IR, CMD_SHIFT_DR, CMD_IDLE} cmd_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESP} state_t;
  localparam int IR_ENTRY = 4;
  localparam int DR_ENTRY = 3;
  localparam int EXIT_LEN = 2;
  localparam int RESET_LEN = 6;
  function automatic int entry_len(cmd_t t);
    return t == CMD_SHIFT_IR ? IR_ENTRY : t == CMD_SHIFT_DR ? DR_ENTRY : 0;
  endfunction
  function automatic int seq_total(cmd_t t, int len);
    return t == CMD_RESET ? RESET_LEN : len == 0 ? 0 : t == CMD_IDLE ? len : entry_len(t) + len + EXIT_LEN;
  endfunction
  function automatic logic in_shift(cmd_t t, int len, int s);
    return (t == CMD_SHIFT_IR || t == CMD_SHIFT_DR) && s >= entry_len(t) && s < entry_len(t) + len;
  endfunction
  function automatic logic step_tms(cmd_t t, int len, int s);
    int e = entry_len(t);
    return t == CMD_RESET ? s < RESET_LEN - 1 :
           t == CMD_IDLE ? 1'b0 :
           s < e ? s < e - 2 :
           s >= e + len - 1 && s <= e + len;
  endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divided TCK with single-cycle rise/fall strobes, held low while disabled
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = en && cnt == CW'(CLK_DIV - 1);
  assign rise = wrap && !tck;
  assign fall = wrap && tck;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      tck <= tck ^ wrap;
    end
endmodule

// File: rtl/jtag_master.sv
// jtag_master: one-command-at-a-time JTAG engine driving TCK/TMS/TDI and capturing TDO
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy
);
  localparam int SW = $clog2(MAX_LEN + 8);
  state_t state, state_n;
  cmd_t typ, t_n;
  logic [LEN_W-1:0] len_q;
  logic [MAX_LEN-1:0] data_q, d_n, cap;
  logic [SW-1:0] step;
  logic rise, fall, accept, last, tms_n, tdi_n, cap_bit;
  int len_in, l_n, s_n, k_n, k_c;
  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk(clk), .rst_n(rst_n), .en(state == ST_RUN), .tck(tck), .rise(rise), .fall(fall)
  );
  // next-step values come from the inputs on accept, otherwise from the latched command
  always_comb begin
    accept  = state == ST_IDLE && cmd_valid;
    len_in  = int'(cmd_len) > MAX_LEN ? MAX_LEN : int'(cmd_len);
    t_n     = accept ? cmd_t'(cmd_type) : typ;
    l_n     = accept ? len_in : int'(len_q);
    d_n     = accept ? cmd_data : data_q;
    s_n     = accept ? 0 : int'(step) + 1;
    k_n     = s_n - entry_len(t_n);
    tms_n   = step_tms(t_n, l_n, s_n);
    tdi_n   = in_shift(t_n, l_n, s_n) && |(d_n & (MAX_LEN'(1) << k_n));
    k_c     = int'(step) - entry_len(typ);
    cap_bit = in_shift(typ, int'(len_q), int'(step));
    last    = int'(step) + 1 >= seq_total(typ, int'(len_q));
    state_n = state == ST_IDLE ? (accept ? (seq_total(t_n, l_n) == 0 ? ST_RESP : ST_RUN) : ST_IDLE) :
              state == ST_RUN  ? (fall && last ? ST_RESP : ST_RUN) :
              rsp_ready ? ST_IDLE : ST_RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ST_IDLE;
      typ    <= CMD_RESET;
      len_q  <= '0;
      data_q <= '0;
      cap    <= '0;
      step   <= '0;
      tms    <= 1'b1;
      tdi    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        typ    <= t_n;
        len_q  <= LEN_W'(len_in);
        data_q <= cmd_data;
        cap    <= '0;
        step   <= '0;
        if (state_n == ST_RUN) begin
          tms <= tms_n;
          tdi <= tdi_n;
        end
      end
      if (state == ST_RUN && rise && cap_bit) cap <= cap | (MAX_LEN'(tdo) << k_c);
      if (state == ST_RUN && fall) begin
        step <= step + SW'(1);
        tms  <= last ? tms : tms_n;
        tdi  <= last ? 1'b0 : tdi_n;
      end
    end
  assign cmd_ready = state == ST_IDLE;
  assign rsp_valid = state == ST_RESP;
  assign rsp_data  = cap;
  assign busy      = state != ST_IDLE;
endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG engine: drives TCK/TMS/TDI and samples TDO toward a target TAP controller.
- Accepts one command at a time: TAP reset, IR shift, DR shift or Run-Test/Idle clocking. Returns captured TDO bits on a response channel.
- Sits between a system-clock command source (debug bridge / CPU CSR) and the JTAG pins. All logic runs on CLK; TCK is a divided, registered output.

Parameters:
- CLK_DIV, 2, CLK cycles per TCK half-period (>=1)
- MAX_LEN, 32, maximum bits per shift command
- LEN_W, 6, width of CMD_LEN (must hold MAX_LEN)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when VALID&&READY on CLK edge
- CMD_TYPE  in  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE
- CMD_LEN  in  LEN_W  bit count (shift) or TCK count (IDLE); values >MAX_LEN clamp to MAX_LEN
- CMD_DATA  in  MAX_LEN  TDI bits, LSB shifted first
- RSP_VALID  out  1  response available; held until RSP_READY
- RSP_READY  in  1  response consumed
- RSP_DATA  out  MAX_LEN  captured TDO, bit i = i-th shifted bit, unused upper bits 0
- TCK  out  1  JTAG clock, idles low
- TMS  out  1  JTAG mode select
- TDI  out  1  JTAG data to target
- TDO  in  1  JTAG data from target
- BUSY  out  1  command in progress or response pending

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, CMD_READY=1, RSP_VALID=0, RSP_DATA=0, BUSY=0.
- RST_N assertion mid-command aborts immediately. The captured result is discarded and no response is issued. The target TAP state is then undefined; software must issue RESET.
- FSM states:
  - IDLE: CMD_READY=1. On accept, latch the command, clear the capture register and go to RUN.
  - RUN: walk the TMS sequence below.
  - RESP: RSP_VALID=1 until RSP_READY, then IDLE.
- CMD_READY=0 in RUN and RESP.
- TCK period = 2*CLK_DIV CLK cycles, generated by a free-running phase counter that is enabled only in RUN.
- Per TCK cycle:
  - TMS/TDI update on the CLK edge that starts the low phase, i.e. the falling edge, or entry into RUN.
  - TDO is sampled into the capture register on the CLK edge that drives TCK 0->1.
- Every command except RESET starts and ends with the target in Run-Test/Idle.
- TMS sequences (one entry per TCK):
  - RESET: 1,1,1,1,1,0 (6 TCK). Ends in Run-Test/Idle.
  - SHIFT_IR:
    - Entry: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
    - Shift: LEN bits with TMS=0, except the last bit with TMS=1 (Exit1-IR).
    - Exit: 1,0 (Update-IR, Run-Test/Idle).
    - Total LEN+6 TCK.
  - SHIFT_DR: entry 1,0,0, then shift and exit as SHIFT_IR. Total LEN+5 TCK.
  - IDLE: LEN TCK with TMS=0.
- TDI carries CMD_DATA[k] during shift bit k. Outside shift cycles TDI=0.
- TDO is captured only during shift bits, into RSP_DATA[k]. The value sampled in the TCK cycle that presents TDI bit k is RSP_DATA[k].
- LEN=0 for SHIFT_IR/SHIFT_DR/IDLE: no TCK is generated; go directly to RESP with RSP_DATA=0.
- After the final TCK falling phase completes, TCK stays 0 and TMS holds its last value (0). RSP_VALID rises on the next CLK.
- Back-to-back: the next command may be accepted the cycle after the RSP handshake. There is no overlap.

Decomposition:
- Shared package jtag_pkg:
  - CMD_RESET/CMD_SHIFT_IR/CMD_SHIFT_DR/CMD_IDLE codes.
  - FSM state encodings.
  - Entry/exit TMS lengths (IR entry 4, DR entry 3, exit 2, reset 6).
- Sub-module jtag_tck_gen, parameterised by CLK_DIV:
  - Inputs: enable.
  - Outputs: TCK plus single-cycle RISE and FALL strobes.
  - The master FSM advances only on these strobes.

Test Plan:
- CLK_DIV=2, RESET -> exactly 6 TCK pulses, each 4 CLK long. TMS sampled at TCK rise = 1,1,1,1,1,0. RSP_VALID once, RSP_DATA=0.
- SHIFT_IR LEN=4 DATA=4'hA into a bench TAP model (IR capture value 4'b0001) -> TMS at rises 1,1,0,0,0,0,0,1,1,0. TDI at shift rises 0,1,0,1. RSP_DATA=32'h1. Model IR=4'hA after Update-IR.
- SHIFT_DR LEN=32 DATA=0 with model IDCODE 32'h1234_5677 selected -> 37 TCK, RSP_DATA=32'h1234_5677.
- IDLE LEN=0 -> no TCK edge, RSP_VALID one cycle after accept. IDLE LEN=3 -> 3 TCK with TMS=0.
- RSP_READY held low 20 cycles after a shift -> RSP_VALID/RSP_DATA stable, CMD_READY=0, no TCK activity. The command presented meanwhile is accepted only after the handshake.
- RST_N pulsed low at the 10th TCK of a 32-bit DR shift -> TCK=0 and TMS=1 asynchronously, no RSP_VALID. A following RESET brings the model to Test-Logic-Reset and then Run-Test/Idle.
